// File: rtl/fpu_operand_unpack_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_operand_unpack_if
// Brief    : Operand-pair handshake and decoded-field bundle for the unpacker.
// Revision : 1.0
// ============================================================================
interface fpu_operand_unpack_if #(
    parameter int TAG_W = 5
);
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      op_a_i;
    logic [31:0]      op_b_i;
    logic [TAG_W-1:0] tag_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [TAG_W-1:0] tag_o;
    logic             sign_a_o;
    logic             sign_b_o;
    logic [7:0]       exp_a_o;
    logic [7:0]       exp_b_o;
    logic [23:0]      sig_a_o;
    logic [23:0]      sig_b_o;
    logic             inf_a_o;
    logic             inf_b_o;
    logic             nan_a_o;
    logic             nan_b_o;
    logic             snan_a_o;
    logic             snan_b_o;
    logic             zero_a_o;
    logic             zero_b_o;
    logic             subn_a_o;
    logic             subn_b_o;
    logic [9:0]       class_a_o;
    logic [9:0]       class_b_o;
    logic             signaling_o;

    modport slave (
        input  flush_i, in_valid_i, op_a_i, op_b_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, tag_o,
        output sign_a_o, sign_b_o, exp_a_o, exp_b_o, sig_a_o, sig_b_o,
        output inf_a_o, inf_b_o, nan_a_o, nan_b_o, snan_a_o, snan_b_o,
        output zero_a_o, zero_b_o, subn_a_o, subn_b_o,
        output class_a_o, class_b_o, signaling_o
    );

    modport master (
        output flush_i, in_valid_i, op_a_i, op_b_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, tag_o,
        input  sign_a_o, sign_b_o, exp_a_o, exp_b_o, sig_a_o, sig_b_o,
        input  inf_a_o, inf_b_o, nan_a_o, nan_b_o, snan_a_o, snan_b_o,
        input  zero_a_o, zero_b_o, subn_a_o, subn_b_o,
        input  class_a_o, class_b_o, signaling_o
    );
endinterface
`default_nettype wire

// File: rtl/fpu_operand_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fpu_operand_unpack
// Brief    : Two-stage binary32 operand unpack/classify front-end with FCLASS.
// Revision : 1.0
// ============================================================================
module fpu_operand_unpack #(
    parameter int TAG_W = 5
) (
    input  wire                  clk_i,
    input  wire                  reset_i,
    fpu_operand_unpack_if.slave  bus
);
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        inf;
        logic        nan;
        logic        snan;
        logic        zero;
        logic        subn;
        logic [9:0]  cls;
    } dec_t;

    localparam logic [9:0] C_CLS_NEG_INF  = 10'b00_0000_0001;
    localparam logic [9:0] C_CLS_NEG_NORM = 10'b00_0000_0010;
    localparam logic [9:0] C_CLS_NEG_SUBN = 10'b00_0000_0100;
    localparam logic [9:0] C_CLS_NEG_ZERO = 10'b00_0000_1000;
    localparam logic [9:0] C_CLS_POS_ZERO = 10'b00_0001_0000;
    localparam logic [9:0] C_CLS_POS_SUBN = 10'b00_0010_0000;
    localparam logic [9:0] C_CLS_POS_NORM = 10'b00_0100_0000;
    localparam logic [9:0] C_CLS_POS_INF  = 10'b00_1000_0000;
    localparam logic [9:0] C_CLS_SNAN     = 10'b01_0000_0000;
    localparam logic [9:0] C_CLS_QNAN     = 10'b10_0000_0000;

    function automatic dec_t decode(input logic [31:0] op);
        dec_t d;
        logic exp_ones;
        logic exp_zero;
        logic frac_zero;
        exp_ones  = (op[30:23] == 8'hFF);
        exp_zero  = (op[30:23] == 8'h00);
        frac_zero = (op[22:0] == 23'd0);

        d.sign = op[31];
        d.exp  = op[30:23];
        d.sig  = {~exp_zero, op[22:0]};
        d.inf  = exp_ones & frac_zero;
        d.nan  = exp_ones & ~frac_zero;
        d.snan = exp_ones & ~frac_zero & ~op[22];
        d.zero = exp_zero & frac_zero;
        d.subn = exp_zero & ~frac_zero;

        // NaN classes ignore the sign; everything else splits by sign.
        if (d.nan) begin
            d.cls = d.snan ? C_CLS_SNAN : C_CLS_QNAN;
        end else if (d.inf) begin
            d.cls = d.sign ? C_CLS_NEG_INF : C_CLS_POS_INF;
        end else if (d.zero) begin
            d.cls = d.sign ? C_CLS_NEG_ZERO : C_CLS_POS_ZERO;
        end else if (d.subn) begin
            d.cls = d.sign ? C_CLS_NEG_SUBN : C_CLS_POS_SUBN;
        end else begin
            d.cls = d.sign ? C_CLS_NEG_NORM : C_CLS_POS_NORM;
        end
        return d;
    endfunction

    logic             s1_valid_q;
    logic             s1_valid_d;
    logic [31:0]      s1_a_q;
    logic [31:0]      s1_b_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic             s2_valid_d;
    logic [TAG_W-1:0] s2_tag_q;
    dec_t             s2_dec_a_q;
    dec_t             s2_dec_b_q;

    logic w_s2_ready;
    logic w_s1_ready;
    logic w_in_fire;
    logic w_s1_fire;

    assign w_s2_ready = ~s2_valid_q | bus.out_ready_i;
    assign w_s1_ready = ~s1_valid_q | w_s2_ready;
    assign w_in_fire  = bus.in_valid_i & w_s1_ready;
    assign w_s1_fire  = s1_valid_q & w_s2_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            logic [31:0] w_op;
            dec_t        w_dec;
            assign w_op  = (gi == 0) ? s1_a_q : s1_b_q;
            assign w_dec = decode(w_op);
        end
    endgenerate

    // Flush overrides any transfer on the same edge, including a new accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (bus.flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (w_s1_fire) begin
                s2_valid_d = 1'b1;
            end else if (bus.out_ready_i) begin
                s2_valid_d = 1'b0;
            end
            if (w_in_fire) begin
                s1_valid_d = 1'b1;
            end else if (w_s1_fire) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (w_in_fire && !bus.flush_i) begin
                s1_a_q   <= bus.op_a_i;
                s1_b_q   <= bus.op_b_i;
                s1_tag_q <= bus.tag_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_dec_a_q <= '0;
            s2_dec_b_q <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (w_s1_fire) begin
                s2_tag_q   <= s1_tag_q;
                s2_dec_a_q <= g_decode[0].w_dec;
                s2_dec_b_q <= g_decode[1].w_dec;
            end
        end
    end

    assign bus.in_ready_o  = w_s1_ready;
    assign bus.out_valid_o = s2_valid_q;
    assign bus.tag_o       = s2_tag_q;

    assign bus.sign_a_o  = s2_dec_a_q.sign;
    assign bus.exp_a_o   = s2_dec_a_q.exp;
    assign bus.sig_a_o   = s2_dec_a_q.sig;
    assign bus.inf_a_o   = s2_dec_a_q.inf;
    assign bus.nan_a_o   = s2_dec_a_q.nan;
    assign bus.snan_a_o  = s2_dec_a_q.snan;
    assign bus.zero_a_o  = s2_dec_a_q.zero;
    assign bus.subn_a_o  = s2_dec_a_q.subn;
    assign bus.class_a_o = s2_dec_a_q.cls;

    assign bus.sign_b_o  = s2_dec_b_q.sign;
    assign bus.exp_b_o   = s2_dec_b_q.exp;
    assign bus.sig_b_o   = s2_dec_b_q.sig;
    assign bus.inf_b_o   = s2_dec_b_q.inf;
    assign bus.nan_b_o   = s2_dec_b_q.nan;
    assign bus.snan_b_o  = s2_dec_b_q.snan;
    assign bus.zero_b_o  = s2_dec_b_q.zero;
    assign bus.subn_b_o  = s2_dec_b_q.subn;
    assign bus.class_b_o = s2_dec_b_q.cls;

    assign bus.signaling_o = s2_dec_a_q.snan | s2_dec_b_q.snan;
endmodule
`default_nettype wire
